// File: rtl/yqc_calc_pkg.sv
// Shared definitions for the calculator sequencing controller:
// key codes, ALU operator encoding and controller states.
package yqc_calc_pkg;

    localparam int unsigned KEY_W = 4;
    localparam int unsigned OP_W  = 2;
    localparam int unsigned WD_W  = 8;

    localparam logic [KEY_W-1:0] KEY_LOAD_A = 4'h0;
    localparam logic [KEY_W-1:0] KEY_LOAD_B = 4'h1;
    localparam logic [KEY_W-1:0] KEY_OP_ADD = 4'h2;
    localparam logic [KEY_W-1:0] KEY_OP_SUB = 4'h3;
    localparam logic [KEY_W-1:0] KEY_OP_MUL = 4'h4;
    localparam logic [KEY_W-1:0] KEY_OP_DIV = 4'h5;
    localparam logic [KEY_W-1:0] KEY_EXEC   = 4'h6;
    localparam logic [KEY_W-1:0] KEY_ANS    = 4'h7;
    localparam logic [KEY_W-1:0] KEY_CLEAR  = 4'h8;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

endpackage

// File: rtl/yqc_calc_wdog.sv
// Loadable down-counter watchdog; expire pulses for one cycle, registered,
// in the cycle after the count steps from 1 to 0 while enabled.
module yqc_calc_wdog
    import yqc_calc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            en,
    input  logic [WD_W-1:0] ld_val,
    output logic            expire
);

    logic [WD_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (load) begin
            cnt    <= ld_val;
            expire <= 1'b0;
        end else if (en) begin
            expire <= (cnt == WD_W'(1));
            if (cnt != '0) begin
                cnt <= cnt - WD_W'(1);
            end
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/yqc_calc_ctrl.sv
// Calculator sequencing controller: latches operands/operator from key events,
// issues one ALU start, waits for done under a watchdog and drives the display result.
module yqc_calc_ctrl
    import yqc_calc_pkg::*;
#(
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 255
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_vld,
    input  logic [3:0]   key,
    input  logic [W-1:0] data_in,
    output logic         alu_start,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [1:0]   alu_op,
    input  logic         alu_done,
    input  logic [W-1:0] alu_result,
    input  logic         alu_ovf,
    output logic [W-1:0] data_out,
    output logic         result_vld,
    output logic         err,
    output logic         busy
);

    state_t       state, state_nxt;
    logic         a_vld, b_vld, a_vld_nxt, b_vld_nxt;
    logic [W-1:0] a_nxt, b_nxt, dout_nxt;
    logic [1:0]   op_nxt;
    logic         rv_nxt, err_nxt, start_nxt, busy_nxt;
    logic         wd_load, wd_en, wd_expire;
    logic         key_clr;

    assign key_clr = key_vld && (key == KEY_CLEAR);
    assign wd_en   = (state == WAIT);

    // expire is registered (one cycle late), so preload one less than TIMEOUT
    // to bound WAIT at exactly TIMEOUT cycles.
    yqc_calc_wdog u_wdog (
        .clk    (clk),
        .rst    (rst),
        .load   (wd_load),
        .en     (wd_en),
        .ld_val (8'(TIMEOUT - 1)),
        .expire (wd_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= OP_ADD;
            a_vld      <= 1'b0;
            b_vld      <= 1'b0;
            alu_start  <= 1'b0;
            data_out   <= '0;
            result_vld <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            alu_a      <= a_nxt;
            alu_b      <= b_nxt;
            alu_op     <= op_nxt;
            a_vld      <= a_vld_nxt;
            b_vld      <= b_vld_nxt;
            alu_start  <= start_nxt;
            data_out   <= dout_nxt;
            result_vld <= rv_nxt;
            err        <= err_nxt;
            busy       <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        a_nxt     = alu_a;
        b_nxt     = alu_b;
        op_nxt    = alu_op;
        a_vld_nxt = a_vld;
        b_vld_nxt = b_vld;
        dout_nxt  = data_out;
        rv_nxt    = result_vld;
        err_nxt   = err;
        wd_load   = 1'b0;

        case (state)
            IDLE: begin
                if (key_vld) begin
                    case (key)
                        KEY_LOAD_A: begin
                            a_nxt     = data_in;
                            a_vld_nxt = 1'b1;
                            err_nxt   = 1'b0;
                        end
                        KEY_LOAD_B: begin
                            b_nxt     = data_in;
                            b_vld_nxt = 1'b1;
                            err_nxt   = 1'b0;
                        end
                        KEY_OP_ADD: op_nxt = OP_ADD;
                        KEY_OP_SUB: op_nxt = OP_SUB;
                        KEY_OP_MUL: op_nxt = OP_MUL;
                        KEY_OP_DIV: op_nxt = OP_DIV;
                        KEY_ANS: begin
                            if (result_vld) begin
                                a_nxt     = data_out;
                                a_vld_nxt = 1'b1;
                            end
                        end
                        KEY_EXEC: begin
                            if (a_vld && b_vld) begin
                                // Division by zero is caught here and never reaches the ALU.
                                if ((alu_op == OP_DIV) && (alu_b == '0)) begin
                                    err_nxt  = 1'b1;
                                    dout_nxt = '0;
                                    rv_nxt   = 1'b0;
                                end else begin
                                    state_nxt = ISSUE;
                                    rv_nxt    = 1'b0;
                                    err_nxt   = 1'b0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ISSUE: begin
                wd_load   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    dout_nxt  = alu_result;
                    rv_nxt    = 1'b1;
                    err_nxt   = alu_ovf;
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    dout_nxt  = '0;
                    rv_nxt    = 1'b0;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // CLEAR overrides everything, including a coincident alu_done.
        if (key_clr) begin
            state_nxt = IDLE;
            a_nxt     = '0;
            b_nxt     = '0;
            op_nxt    = OP_ADD;
            a_vld_nxt = 1'b0;
            b_vld_nxt = 1'b0;
            dout_nxt  = '0;
            rv_nxt    = 1'b0;
            err_nxt   = 1'b0;
        end

        start_nxt = (state_nxt == ISSUE);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_yqc_calc_ctrl.sv
// Scoreboard bench for yqc_calc_ctrl: a key-level reference model predicts ALU
// starts and completed results; a monitor pops and compares them as they appear.
module tb_yqc_calc_ctrl;
    import yqc_calc_pkg::*;

    localparam int unsigned W  = 8;
    localparam int unsigned TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_vld = 1'b0;
    logic [3:0]   key = 4'h0;
    logic [W-1:0] data_in = '0;
    logic         alu_start;
    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alu_op;
    logic         alu_done = 1'b0;
    logic [W-1:0] alu_result = '0;
    logic         alu_ovf = 1'b0;
    logic [W-1:0] data_out;
    logic         result_vld, err, busy;

    always #5 clk = ~clk;

    yqc_calc_ctrl #(.W(W), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .key_vld    (key_vld),
        .key        (key),
        .data_in    (data_in),
        .alu_start  (alu_start),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .alu_ovf    (alu_ovf),
        .data_out   (data_out),
        .result_vld (result_vld),
        .err        (err),
        .busy       (busy)
    );

    typedef struct packed { logic [W-1:0] a; logic [W-1:0] b; logic [1:0] op; } start_t;
    typedef struct packed { logic [W-1:0] d; logic rv; logic er; } res_t;

    start_t sq[$];
    res_t   rq[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state at key level.
    logic [W-1:0] m_a, m_b, m_do;
    logic [1:0]   m_op;
    bit           m_av, m_bv, m_rv, m_err, m_busy;
    bit           alu_mute = 1'b0;
    int           alu_dly = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [1:0] op,
                                    output logic [W-1:0] r, output logic o);
        int unsigned x;
        case (op)
            2'd0: begin x = 32'(a) + 32'(b); r = W'(x); o = (x >> W) != 0; end
            2'd1: begin r = W'(32'(a) - 32'(b)); o = (a < b); end
            2'd2: begin x = 32'(a) * 32'(b); r = W'(x); o = (x >> W) != 0; end
            default: begin r = (b == '0) ? '0 : W'(a / b); o = 1'b0; end
        endcase
    endfunction

    task automatic model_clear();
        m_a = '0; m_b = '0; m_op = 2'd0; m_av = 0; m_bv = 0;
        m_do = '0; m_rv = 0; m_err = 0; m_busy = 0;
    endtask

    task automatic apply_key(input logic [3:0] k, input logic [W-1:0] d);
        logic [W-1:0] r;
        logic         o;
        case (k)
            4'd0: begin m_a = d; m_av = 1; m_err = 0; end
            4'd1: begin m_b = d; m_bv = 1; m_err = 0; end
            4'd2, 4'd3, 4'd4, 4'd5: m_op = 2'(k - 4'd2);
            4'd6: begin
                if (m_av && m_bv) begin
                    if (m_op == 2'd3 && m_b == '0) begin
                        m_err = 1; m_do = '0; m_rv = 0;
                    end else begin
                        sq.push_back('{m_a, m_b, m_op});
                        m_busy = 1; m_rv = 0; m_err = 0;
                        if (!alu_mute) begin
                            alu_ref(m_a, m_b, m_op, r, o);
                            m_do = r; m_rv = 1; m_err = o;
                            rq.push_back('{r, 1'b1, o});
                        end
                    end
                end
            end
            4'd7: if (m_rv) begin m_a = m_do; m_av = 1; end
            4'd8: model_clear();
            default: ;
        endcase
    endtask

    // Called at posedge+1; leaves control at the following posedge+1.
    task automatic send_key(input logic [3:0] k, input logic [W-1:0] d);
        key_vld = 1'b1; key = k; data_in = d;
        @(posedge clk); #1;
        key_vld = 1'b0; key = 4'($urandom); data_in = W'($urandom);
        if (m_busy) begin
            if (k == KEY_CLEAR) begin
                rq.push_back('{'0, 1'b0, 1'b0});
                model_clear();
            end
        end else begin
            apply_key(k, d);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (busy) chk("wait_idle bound", 32'(busy), 32'd0);
        m_busy = 0;
    endtask

    task automatic check_regs(input string tag);
        chk($sformatf("%s alu_a", tag), 32'(alu_a), 32'(m_a));
        chk($sformatf("%s alu_b", tag), 32'(alu_b), 32'(m_b));
        chk($sformatf("%s alu_op", tag), 32'(alu_op), 32'(m_op));
        chk($sformatf("%s data_out", tag), 32'(data_out), 32'(m_do));
        chk($sformatf("%s result_vld", tag), 32'(result_vld), 32'(m_rv));
        chk($sformatf("%s err", tag), 32'(err), 32'(m_err));
        chk($sformatf("%s busy", tag), 32'(busy), 32'(m_busy));
    endtask

    // Behavioural multi-cycle ALU.
    initial begin
        logic [W-1:0] ra;
        logic         ro;
        int           d;
        forever begin
            @(posedge clk); #2;
            if (alu_start && !alu_mute && !rst) begin
                alu_ref(alu_a, alu_b, alu_op, ra, ro);
                d = (alu_dly != 0) ? alu_dly : int'($urandom_range(1, 5));
                repeat (d) @(posedge clk);
                #1;
                alu_result = ra; alu_ovf = ro; alu_done = 1'b1;
                @(posedge clk); #1;
                alu_done = 1'b0; alu_result = W'($urandom); alu_ovf = 1'($urandom);
            end
        end
    end

    // Monitor: compares every start pulse and every busy->idle transition.
    initial begin
        bit     pb;
        start_t s;
        res_t   q;
        pb = 0;
        forever begin
            @(negedge clk);
            if (alu_start) begin
                if (sq.size() == 0) chk("unexpected alu_start", 32'd1, 32'd0);
                else begin
                    s = sq.pop_front();
                    chk("start alu_a", 32'(alu_a), 32'(s.a));
                    chk("start alu_b", 32'(alu_b), 32'(s.b));
                    chk("start alu_op", 32'(alu_op), 32'(s.op));
                end
            end
            if (pb && !busy) begin
                if (rq.size() == 0) chk("unexpected completion", 32'd1, 32'd0);
                else begin
                    q = rq.pop_front();
                    chk("result data_out", 32'(data_out), 32'(q.d));
                    chk("result result_vld", 32'(result_vld), 32'(q.rv));
                    chk("result err", 32'(err), 32'(q.er));
                end
            end
            pb = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_regs("reset");
        chk("reset alu_start", 32'(alu_start), 32'd0);

        // 3 + 5 with done two cycles after start
        alu_dly = 2;
        send_key(KEY_LOAD_A, 8'h03);
        send_key(KEY_LOAD_B, 8'h05);
        send_key(KEY_OP_ADD, 8'h00);
        send_key(KEY_EXEC, 8'h00);
        wait_idle();
        chk("t1 data_out", 32'(data_out), 32'h08);
        chk("t1 result_vld", 32'(result_vld), 32'd1);
        check_regs("t1");

        // 12 / 4, then chain with ANS * 2
        send_key(KEY_LOAD_A, 8'h0C);
        send_key(KEY_LOAD_B, 8'h04);
        send_key(KEY_OP_DIV, 8'h00);
        send_key(KEY_EXEC, 8'h00);
        wait_idle();
        chk("t2 div data_out", 32'(data_out), 32'h03);
        send_key(KEY_ANS, 8'hEE);
        chk("t2 ans alu_a", 32'(alu_a), 32'h03);
        send_key(KEY_LOAD_B, 8'h02);
        send_key(KEY_OP_MUL, 8'h00);
        send_key(KEY_EXEC, 8'h00);
        wait_idle();
        chk("t2 mul data_out", 32'(data_out), 32'h06);
        check_regs("t2");

        // Divide by zero
        send_key(KEY_LOAD_A, 8'h0C);
        send_key(KEY_LOAD_B, 8'h00);
        send_key(KEY_OP_DIV, 8'h00);
        send_key(KEY_EXEC, 8'h00);
        chk("t3 err", 32'(err), 32'd1);
        chk("t3 data_out", 32'(data_out), 32'h00);
        chk("t3 busy", 32'(busy), 32'd0);
        send_key(KEY_LOAD_A, 8'h01);
        chk("t3 err cleared", 32'(err), 32'd0);
        check_regs("t3");

        // Timeout with a silent ALU, then a late done
        alu_mute = 1;
        send_key(KEY_LOAD_B, 8'h09);
        send_key(KEY_OP_ADD, 8'h00);
        send_key(KEY_EXEC, 8'h00);
        rq.push_back('{'0, 1'b0, 1'b1});
        n = 0;
        while (busy && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t4 wait cycles", 32'(n - 1), 32'(TO));
        chk("t4 err", 32'(err), 32'd1);
        m_busy = 0; m_err = 1; m_do = '0; m_rv = 0;
        alu_done = 1'b1; alu_result = 8'h55; alu_ovf = 1'b0;
        @(posedge clk); #1;
        alu_done = 1'b0;
        check_regs("t4 late done");

        // CLEAR coincident with alu_done
        send_key(KEY_LOAD_A, 8'h20);
        send_key(KEY_EXEC, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        key_vld = 1'b1; key = KEY_CLEAR; alu_done = 1'b1; alu_result = 8'h55;
        @(posedge clk); #1;
        key_vld = 1'b0; alu_done = 1'b0;
        rq.push_back('{'0, 1'b0, 1'b0});
        model_clear();
        check_regs("t5 clear");
        send_key(KEY_EXEC, 8'h00);
        check_regs("t5 exec after clear");

        // Early EXEC, keys ignored in WAIT, illegal key, reset mid-WAIT
        send_key(KEY_LOAD_A, 8'h05);
        send_key(KEY_EXEC, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        check_regs("t6 exec A only");
        send_key(KEY_LOAD_B, 8'h02);
        send_key(KEY_OP_SUB, 8'h00);
        send_key(KEY_EXEC, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        send_key(KEY_LOAD_B, 8'h07);
        check_regs("t6 load_b in wait");
        send_key(4'hF, 8'hAA);
        check_regs("t6 key F in wait");
        rq.push_back('{'0, 1'b0, 1'b0});
        rst = 1'b1;
        #2;
        model_clear();
        check_regs("t6 async reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_regs("t6 after reset");
        chk("t6 alu_start", 32'(alu_start), 32'd0);

        // Randomized key streams against the model
        alu_mute = 0;
        alu_dly  = 0;
        for (int i = 0; i < 120; i++) begin
            int unsigned r;
            logic [3:0]   k;
            logic [W-1:0] d;
            r = $urandom_range(0, 19);
            if (r < 4)       k = KEY_LOAD_A;
            else if (r < 8)  k = KEY_LOAD_B;
            else if (r < 12) k = 4'(2 + $urandom_range(0, 3));
            else if (r < 16) k = KEY_EXEC;
            else if (r < 18) k = KEY_ANS;
            else if (r < 19) k = KEY_CLEAR;
            else             k = 4'($urandom_range(9, 15));
            d = ($urandom_range(0, 3) == 0) ? W'(0) : W'($urandom);
            send_key(k, d);
            if (m_busy) wait_idle();
            check_regs("rand");
        end

        repeat (3) @(posedge clk);
        #1;
        chk("start queue drained", 32'(sq.size()), 32'd0);
        chk("result queue drained", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
